// File: rtl/fmps_link_arbiter.sv
// Packet-granular round-robin merge of CCW/CW FMPS tx links with per-FA-cycle packet counts.
// Zero-latency pass-through after one IDLE arbitration cycle; m_tready backpressures the granted link only; runaway packets truncate then drain.
module fmps_link_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int MAX_PKT_WORDS = 4,
  parameter int COUNT_WIDTH   = 6
) (
  input  logic                   auClk,
  input  logic                   auReset,
  input  logic                   auFAstrobe,
  input  logic                   s0_tvalid,
  input  logic                   s0_tlast,
  input  logic [DATA_WIDTH-1:0]  s0_tdata,
  output logic                   s0_tready,
  input  logic                   s1_tvalid,
  input  logic                   s1_tlast,
  input  logic [DATA_WIDTH-1:0]  s1_tdata,
  output logic                   s1_tready,
  output logic                   m_tvalid,
  output logic                   m_tlast,
  output logic [DATA_WIDTH-1:0]  m_tdata,
  input  logic                   m_tready,
  output logic                   m_tuser,
  output logic [COUNT_WIDTH-1:0] pktCount0,
  output logic [COUNT_WIDTH-1:0] pktCount1,
  output logic                   lengthErrorStrobe
);

  localparam int WCW = $clog2(MAX_PKT_WORDS + 1);

  typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic                   grant_q, grant_d;
  logic                   last_grant_q, last_grant_d;
  logic [WCW-1:0]         word_cnt_q, word_cnt_d;
  logic [COUNT_WIDTH-1:0] live0_q, live0_d, live1_q, live1_d;
  logic [COUNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic                   len_err_q, len_err_d;

  logic                   sel_vld, sel_last, at_limit, pkt_done;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [COUNT_WIDTH-1:0] live0_nxt, live1_nxt;

  assign sel_vld  = grant_q ? s1_tvalid : s0_tvalid;
  assign sel_last = grant_q ? s1_tlast  : s0_tlast;
  assign sel_data = grant_q ? s1_tdata  : s0_tdata;
  // The word about to transfer is the last one a packet may carry.
  assign at_limit = (word_cnt_q == WCW'(MAX_PKT_WORDS - 1));

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    word_cnt_d   = word_cnt_q;
    len_err_d    = 1'b0;
    pkt_done     = 1'b0;
    s0_tready    = 1'b0;
    s1_tready    = 1'b0;
    m_tvalid     = 1'b0;
    m_tlast      = 1'b0;
    m_tdata      = '0;
    m_tuser      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (s0_tvalid || s1_tvalid) begin
          grant_d    = (s0_tvalid && s1_tvalid) ? ~last_grant_q : s1_tvalid;
          word_cnt_d = '0;
          state_d    = PASS;
        end
      end
      PASS: begin
        m_tvalid  = sel_vld;
        m_tdata   = sel_data;
        m_tlast   = sel_last | at_limit;
        m_tuser   = grant_q;
        s0_tready = ~grant_q & m_tready;
        s1_tready = grant_q & m_tready;
        if (sel_vld && m_tready) begin
          word_cnt_d = word_cnt_q + WCW'(1);
          if (sel_last || at_limit) begin
            pkt_done     = 1'b1;
            last_grant_d = grant_q;
            len_err_d    = ~sel_last;
            state_d      = sel_last ? IDLE : DRAIN;
          end
        end
      end
      DRAIN: begin
        s0_tready = ~grant_q;
        s1_tready = grant_q;
        if (sel_vld && sel_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Completion in the strobe cycle lands in the latched count, not the new live count.
  always_comb begin
    live0_nxt = live0_q;
    live1_nxt = live1_q;
    if (pkt_done && !grant_q && live0_q != '1) live0_nxt = live0_q + COUNT_WIDTH'(1);
    if (pkt_done &&  grant_q && live1_q != '1) live1_nxt = live1_q + COUNT_WIDTH'(1);
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    live0_d = live0_nxt;
    live1_d = live1_nxt;
    if (auFAstrobe) begin
      cnt0_d  = live0_nxt;
      cnt1_d  = live1_nxt;
      live0_d = '0;
      live1_d = '0;
    end
  end

  always_ff @(posedge auClk or posedge auReset) begin
    if (auReset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      word_cnt_q   <= '0;
      live0_q      <= '0;
      live1_q      <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      word_cnt_q   <= word_cnt_d;
      live0_q      <= live0_d;
      live1_q      <= live1_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
      len_err_q    <= len_err_d;
    end
  end

  assign pktCount0         = cnt0_q;
  assign pktCount1         = cnt1_q;
  assign lengthErrorStrobe = len_err_q;

endmodule

// File: tb/tb_fmps_link_arbiter.sv
// Bench for fmps_link_arbiter: queued packet sources, packet-level round-robin reference model.
module tb_fmps_link_arbiter;
  localparam int DW   = 32;
  localparam int MAXW = 4;
  localparam int CW   = 6;

  logic          auClk = 1'b0;
  logic          auReset, auFAstrobe;
  logic          s0_tvalid, s0_tlast, s0_tready;
  logic [DW-1:0] s0_tdata;
  logic          s1_tvalid, s1_tlast, s1_tready;
  logic [DW-1:0] s1_tdata;
  logic          m_tvalid, m_tlast, m_tready, m_tuser;
  logic [DW-1:0] m_tdata;
  logic [CW-1:0] pktCount0, pktCount1;
  logic          lengthErrorStrobe;

  fmps_link_arbiter #(.DATA_WIDTH(DW), .MAX_PKT_WORDS(MAXW), .COUNT_WIDTH(CW)) dut (
    .auClk(auClk), .auReset(auReset), .auFAstrobe(auFAstrobe),
    .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tdata(s0_tdata), .s0_tready(s0_tready),
    .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tdata(s1_tdata), .s1_tready(s1_tready),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tdata(m_tdata), .m_tready(m_tready),
    .m_tuser(m_tuser), .pktCount0(pktCount0), .pktCount1(pktCount1),
    .lengthErrorStrobe(lengthErrorStrobe)
  );

  always #5 auClk = ~auClk;

  typedef struct packed {logic last; logic [DW-1:0] data;} word_t;
  typedef struct packed {logic user; logic last; logic [DW-1:0] data;} out_t;

  word_t src0[$], src1[$];
  logic [DW-1:0] md0[$], md1[$];
  int len0[$], len1[$];
  out_t exp_q[$], out_q[$];
  int out_cyc[$];

  int checks = 0, errors = 0;
  int cyc = 0, bad_rdy = 0, err_pulses = 0, err_run = 0, max_err_run = 0, exp_err = 0;
  logic mdl_last = 1'b1;
  logic rand_rdy = 1'b0;
  logic strobe_on_last = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    if (src0.size() > 0) begin
      s0_tvalid = 1'b1; s0_tlast = src0[0].last; s0_tdata = src0[0].data;
    end else begin
      s0_tvalid = 1'b0; s0_tlast = 1'b0; s0_tdata = '0;
    end
    if (src1.size() > 0) begin
      s1_tvalid = 1'b1; s1_tlast = src1[0].last; s1_tdata = src1[0].data;
    end else begin
      s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_tdata = '0;
    end
  endtask

  // One clock: observe at negedge, then update sources just after posedge.
  task automatic step();
    logic x0, x1;
    @(negedge auClk);
    x0 = s0_tvalid && s0_tready;
    x1 = s1_tvalid && s1_tready;
    if (m_tvalid && m_tready) begin
      out_q.push_back({m_tuser, m_tlast, m_tdata});
      out_cyc.push_back(cyc);
    end
    if (s0_tready && s1_tready) bad_rdy++;
    if (m_tvalid && (m_tuser ? s0_tready : s1_tready)) bad_rdy++;
    if (lengthErrorStrobe) begin
      err_pulses++; err_run++;
      if (err_run > max_err_run) max_err_run = err_run;
    end else err_run = 0;
    if (strobe_on_last && x0 && s0_tlast) begin
      auFAstrobe = 1'b1;
      strobe_on_last = 1'b0;
    end
    @(posedge auClk);
    #1;
    cyc++;
    auFAstrobe = 1'b0;
    if (x0) void'(src0.pop_front());
    if (x1) void'(src1.pop_front());
    drive();
    if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic add_packet(input int link, input int len, input logic [DW-1:0] base);
    for (int k = 0; k < len; k++) begin
      if (link == 0) begin
        src0.push_back({k == len - 1, base + DW'(k)}); md0.push_back(base + DW'(k));
      end else begin
        src1.push_back({k == len - 1, base + DW'(k)}); md1.push_back(base + DW'(k));
      end
    end
    if (link == 0) len0.push_back(len); else len1.push_back(len);
  endtask

  // Reference: whole packets alternate when both links have one waiting; each is cut to MAXW words.
  task automatic build_expected();
    int p0 = 0, p1 = 0, o0 = 0, o1 = 0, L;
    logic g;
    while (p0 < len0.size() || p1 < len1.size()) begin
      if (p0 < len0.size() && p1 < len1.size()) g = ~mdl_last;
      else g = (p1 < len1.size());
      L = g ? len1[p1] : len0[p0];
      for (int k = 0; k < L && k < MAXW; k++)
        exp_q.push_back({g, (k == L - 1) || (k == MAXW - 1), g ? md1[o1 + k] : md0[o0 + k]});
      if (L > MAXW) exp_err++;
      if (g) begin o1 += L; p1++; end else begin o0 += L; p0++; end
      mdl_last = g;
    end
    md0.delete(); md1.delete(); len0.delete(); len1.delete();
  endtask

  task automatic run_drain(input string tag, input int budget);
    int n = 0;
    drive();
    while ((src0.size() > 0 || src1.size() > 0) && n < budget) begin
      step(); n++;
    end
    repeat (3) step();
    check({tag, " drained"}, 64'(n < budget), 64'(1));
  endtask

  task automatic compare_out(input string tag);
    check({tag, " word count"}, 64'(out_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s word %0d", tag, i), 64'(out_q[i]), 64'(exp_q[i]));
    out_q.delete(); exp_q.delete();
  endtask

  task automatic strobe_check(input string tag, input int e0, input int e1);
    auFAstrobe = 1'b1;
    step();
    check({tag, " pktCount0"}, 64'(pktCount0), 64'(e0));
    check({tag, " pktCount1"}, 64'(pktCount1), 64'(e1));
  endtask

  task automatic apply_reset();
    auReset = 1'b1;
    #1;
    step();
    auReset = 1'b0;
    mdl_last = 1'b1;
  endtask

  initial begin
    int n0, n1, L;
    auReset = 1'b1; auFAstrobe = 1'b0; m_tready = 1'b0;
    src0.delete(); src1.delete();
    drive();
    #12;
    check("reset ctl", 64'({m_tvalid, m_tlast, m_tuser, s0_tready, s1_tready, lengthErrorStrobe}), 64'(0));
    check("reset data", 64'(m_tdata), 64'(0));
    check("reset counts", 64'({pktCount0, pktCount1}), 64'(0));
    @(posedge auClk); #1;
    auReset = 1'b0;

    // Single link, three one-word packets.
    m_tready = 1'b1; rand_rdy = 1'b0;
    for (int n = 0; n < 3; n++) add_packet(0, 1, 32'hCACA0000 + DW'(n));
    build_expected();
    run_drain("single", 100);
    check("single gap01", 64'(out_cyc.size() > 1 ? out_cyc[1] - out_cyc[0] : 0), 64'(2));
    check("single gap12", 64'(out_cyc.size() > 2 ? out_cyc[2] - out_cyc[1] : 0), 64'(2));
    compare_out("single");
    out_cyc.delete();
    strobe_check("single", 3, 0);

    // Contention from reset: CCW first, strict alternation.
    apply_reset();
    for (int n = 0; n < 8; n++) begin
      add_packet(0, int'($urandom_range(1, 3)), $urandom);
      add_packet(1, int'($urandom_range(1, 3)), $urandom);
    end
    build_expected();
    run_drain("contention", 500);
    compare_out("contention");
    strobe_check("contention", 8, 8);

    // Backpressure with two-word packets.
    rand_rdy = 1'b1;
    bad_rdy = 0;
    for (int n = 0; n < 6; n++) begin
      add_packet(0, 2, $urandom);
      add_packet(1, 2, $urandom);
    end
    build_expected();
    run_drain("backpressure", 1000);
    compare_out("backpressure");
    check("backpressure other tready", 64'(bad_rdy), 64'(0));
    strobe_check("backpressure", 6, 6);

    // Runaway CW packet: 6 words without tlast then one with tlast.
    rand_rdy = 1'b0; m_tready = 1'b1;
    err_pulses = 0; max_err_run = 0; exp_err = 0;
    add_packet(1, 7, 32'h5A5A0000);
    build_expected();
    run_drain("runaway", 200);
    compare_out("runaway");
    check("runaway err pulses", 64'(err_pulses), 64'(exp_err));
    check("runaway err width", 64'(max_err_run), 64'(1));
    strobe_check("runaway", 0, 1);

    // Randomized mixed traffic including truncations.
    for (int r = 0; r < 4; r++) begin
      rand_rdy = 1'b1;
      err_pulses = 0; exp_err = 0;
      n0 = int'($urandom_range(0, 6));
      n1 = int'($urandom_range(0, 6));
      for (int n = 0; n < n0; n++) begin
        L = int'($urandom_range(1, 7)); add_packet(0, L, $urandom);
      end
      for (int n = 0; n < n1; n++) begin
        L = int'($urandom_range(1, 7)); add_packet(1, L, $urandom);
      end
      build_expected();
      run_drain($sformatf("random%0d", r), 3000);
      compare_out($sformatf("random%0d", r));
      check($sformatf("random%0d err pulses", r), 64'(err_pulses), 64'(exp_err));
      strobe_check($sformatf("random%0d", r), n0, n1);
    end
    check("random other tready", 64'(bad_rdy), 64'(0));

    // Strobe coincident with a final transfer.
    rand_rdy = 1'b0; m_tready = 1'b1;
    add_packet(0, 1, 32'h11110000);
    build_expected();
    run_drain("coincide a", 100);
    strobe_on_last = 1'b1;
    add_packet(0, 1, 32'h11110001);
    build_expected();
    run_drain("coincide b", 100);
    compare_out("coincide");
    check("coincide strobe fired", 64'(strobe_on_last), 64'(0));
    check("coincide latched", 64'(pktCount0), 64'(2));
    strobe_check("coincide restart", 0, 0);

    // Reset after the first of two words.
    src0.push_back({1'b0, 32'hAAAA0001});
    src0.push_back({1'b1, 32'hAAAA0002});
    drive();
    for (int n = 0; n < 20 && out_q.size() == 0; n++) step();
    check("midreset first word", 64'(out_q.size()), 64'(1));
    #2;
    auReset = 1'b1;
    #1;
    check("midreset ctl", 64'({m_tvalid, m_tlast, m_tuser, s0_tready, s1_tready, lengthErrorStrobe}), 64'(0));
    check("midreset data", 64'(m_tdata), 64'(0));
    check("midreset counts", 64'({pktCount0, pktCount1}), 64'(0));
    src1.push_back({1'b1, 32'hBBBB0001});
    step();
    auReset = 1'b0;
    out_q.delete(); out_cyc.delete();
    exp_q.push_back({1'b0, 1'b1, 32'hAAAA0002});
    exp_q.push_back({1'b1, 1'b1, 32'hBBBB0001});
    run_drain("midreset", 100);
    compare_out("midreset");
    strobe_check("midreset", 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
